// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//   Recovers byte alignment from a serial bit stream using a comma symbol and
//   then delivers each aligned byte in parallel.
//   SEARCH: slide a bit-wise window over the stream looking for COMMA.
//   ALIGN : count bits from where the match completed and require BC_COUNT
//           aligned COMMAs in a row. Any other byte drops back to SEARCH.
//   ACTIVE: emit every byte boundary on data_out/byte_strobe. The link stays
//           ACTIVE until reset; COMMA bytes here are idle fill.
//
// Ports
//   clk_32f     in   bit clock, one serial bit per rising edge
//   reset       in   synchronous, active-low
//   serial_in   in   serial data, MSB of each byte first
//   data_out    out  last completed byte (registered)
//   valid_out   out  high with byte_strobe when the byte is payload (not COMMA)
//   byte_strobe out  one-cycle pulse per new data_out while ACTIVE
//   active      out  link aligned (level)
//   state_dbg   out  current FSM state: 0 SEARCH, 1 ALIGN, 2 ACTIVE
//
// Handshake: byte_strobe is a one-cycle valid with no ready. A byte whose last
// bit is sampled on edge N is presented on data_out/byte_strobe/valid_out
// right after edge N. valid_out is never high without byte_strobe.
module serial_to_parallel_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int BCW = $clog2(BC_COUNT + 1);
  // bc_cnt value at which one more aligned COMMA completes the burst.
  localparam logic [BCW-1:0] BC_LAST = BCW'(BC_COUNT - 1);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(BC_COUNT);

  state_t         state;
  logic [7:0]     sr;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] bc_cnt;

  // The window including the bit being sampled this edge; every comparison
  // uses it so a byte is recognised on the same edge its last bit arrives.
  logic [7:0] next_sr;
  logic       boundary;

  assign next_sr   = {sr[6:0], serial_in};
  assign boundary  = (bit_cnt == 3'd7);
  assign state_dbg = state;

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state       <= SEARCH;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      bc_cnt      <= '0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= next_sr;
      byte_strobe <= 1'b0;
      valid_out   <= 1'b0;

      case (state)
        SEARCH: begin
          // The match point defines the byte boundary from here on.
          if (next_sr == COMMA) begin
            state   <= ALIGN;
            bit_cnt <= 3'd0;
            bc_cnt  <= BCW'(1);
          end
        end

        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (next_sr == COMMA) begin
              if (bc_cnt != BC_MAX) bc_cnt <= bc_cnt + BCW'(1);
              if (bc_cnt == BC_LAST) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Misaligned or corrupted: resume the sliding search next cycle.
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end

        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out    <= next_sr;
            byte_strobe <= 1'b1;
            valid_out   <= (next_sr != COMMA);
          end
        end

        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
